// File: rtl/edsac_tank_sequencer.sv
// EDSAC store sequencer: free-running digit/minor-cycle timing plus single-request
// gating of one short or long word out of (or into) a mercury delay-line tank.
module edsac_tank_sequencer #(
  parameter int unsigned N_TANKS          = 32,
  parameter int unsigned MINORS_PER_TANK  = 32,
  parameter int unsigned DIGITS_PER_MINOR = 18,
  localparam int unsigned TANK_W          = $clog2(N_TANKS),
  localparam int unsigned MINOR_W         = $clog2(MINORS_PER_TANK),
  localparam int unsigned DIGIT_W         = $clog2(DIGITS_PER_MINOR),
  localparam int unsigned ADDR_W          = TANK_W + MINOR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic               req_write,
  input  logic               req_long,
  output logic               ready,
  output logic               done,
  output logic [TANK_W-1:0]  tank_idx,
  output logic               t_in,
  output logic               t_out,
  output logic [DIGIT_W-1:0] digit_cnt,
  output logic [MINOR_W-1:0] minor_cnt,
  output logic               minor_start
);

  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(DIGITS_PER_MINOR - 1);
  localparam logic [MINOR_W-1:0] MINOR_LAST = MINOR_W'(MINORS_PER_TANK - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [DIGIT_W-1:0]  digit_q, digit_d;
  logic [MINOR_W-1:0]  minor_q, minor_d;
  logic [TANK_W-1:0]   tank_q, tank_d;
  logic [MINOR_W-1:0]  target_q, target_d;
  logic                write_q, write_d;
  logic                long_q, long_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                t_in_q, t_in_d;
  logic                t_out_q, t_out_d;
  logic [TANK_W-1:0]   tank_idx_q, tank_idx_d;
  logic                start_q, start_d;

  logic                digit_wrap_c;
  logic [MINOR_W-1:0]  req_target_c;
  logic [MINOR_W-1:0]  last_minor_c;
  logic                hit_req_c;
  logic                hit_lat_c;

  function automatic logic [MINOR_W-1:0] prev_minor(input logic [MINOR_W-1:0] m);
    return (m == '0) ? MINOR_LAST : m - MINOR_W'(1);
  endfunction

  // Free-running digit / minor-cycle counters
  always_comb begin
    digit_wrap_c = (digit_q == DIGIT_LAST);
    digit_d      = digit_wrap_c ? '0 : digit_q + DIGIT_W'(1);
    minor_d      = minor_q;
    if (digit_wrap_c) begin
      minor_d = (minor_q == MINOR_LAST) ? '0 : minor_q + MINOR_W'(1);
    end
    start_d = (digit_d == '0);
  end

  // Gates are registered, so XFER is entered on the last digit of the preceding minor cycle
  assign req_target_c = req_long ? {req_addr[MINOR_W-1:1], 1'b0} : req_addr[MINOR_W-1:0];
  assign last_minor_c = long_q ? (target_q | MINOR_W'(1)) : target_q;
  assign hit_req_c    = digit_wrap_c && (minor_q == prev_minor(req_target_c));
  assign hit_lat_c    = digit_wrap_c && (minor_q == prev_minor(target_q));

  always_comb begin
    state_d  = state_q;
    tank_d   = tank_q;
    target_d = target_q;
    write_d  = write_q;
    long_d   = long_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          tank_d   = req_addr[ADDR_W-1:MINOR_W];
          target_d = req_target_c;
          write_d  = req_write;
          long_d   = req_long;
          state_d  = hit_req_c ? S_XFER : S_WAIT;
        end
      end
      S_WAIT: begin
        if (hit_lat_c) state_d = S_XFER;
      end
      S_XFER: begin
        if (digit_wrap_c && (minor_q == last_minor_c)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d    = (state_d == S_IDLE);
    done_d     = (state_d == S_DONE);
    t_in_d     = (state_d == S_XFER) && write_d;
    t_out_d    = (state_d == S_XFER) && !write_d;
    tank_idx_d = (state_d == S_XFER) ? tank_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      digit_q    <= '0;
      minor_q    <= '0;
      tank_q     <= '0;
      target_q   <= '0;
      write_q    <= 1'b0;
      long_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      t_in_q     <= 1'b0;
      t_out_q    <= 1'b0;
      tank_idx_q <= '0;
      start_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      minor_q    <= minor_d;
      tank_q     <= tank_d;
      target_q   <= target_d;
      write_q    <= write_d;
      long_q     <= long_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      t_in_q     <= t_in_d;
      t_out_q    <= t_out_d;
      tank_idx_q <= tank_idx_d;
      start_q    <= start_d;
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign tank_idx    = tank_idx_q;
  assign t_in        = t_in_q;
  assign t_out       = t_out_q;
  assign digit_cnt   = digit_q;
  assign minor_cnt   = minor_q;
  assign minor_start = start_q;

endmodule

// File: tb/tb_edsac_tank_sequencer.sv
// Directed cycle-by-cycle bench for edsac_tank_sequencer; cycle 0 is the first
// cycle after reset is released, expected windows are hand-computed constants.
module tb_edsac_tank_sequencer;

  localparam int unsigned DIGITS = 18;
  localparam int unsigned MINORS = 32;

  logic       clk;
  logic       rst;
  logic       req;
  logic [9:0] req_addr;
  logic       req_write;
  logic       req_long;
  logic       ready;
  logic       done;
  logic [4:0] tank_idx;
  logic       t_in;
  logic       t_out;
  logic [4:0] digit_cnt;
  logic [4:0] minor_cnt;
  logic       minor_start;

  int n_total;
  int n_bad;

  edsac_tank_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_long    (req_long),
    .ready       (ready),
    .done        (done),
    .tank_idx    (tank_idx),
    .t_in        (t_in),
    .t_out       (t_out),
    .digit_cnt   (digit_cnt),
    .minor_cnt   (minor_cnt),
    .minor_start (minor_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hold reset three cycles; returns 1 time unit into cycle 0.
  task automatic do_reset();
    rst = 1'b1; req = 1'b0; req_addr = '0; req_write = 1'b0; req_long = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Up to two real requests, one spurious request, and an optional reset pulse.
  task automatic run_case(input string name, input int n_last,
                          input int a1, input logic [9:0] addr1, input logic w1, input logic l1,
                          input int lo1, input int hi1, input int tk1, input int d1,
                          input int a2, input logic [9:0] addr2, input logic w2, input logic l2,
                          input int lo2, input int hi2, input int tk2, input int d2,
                          input int spur, input logic [9:0] saddr, input int rstc);
    do_reset();
    for (int n = 0; n <= n_last; n++) begin
      bit post, in1, in2, busy1, busy2;
      int base;
      string pfx;
      post  = (rstc >= 0) && (n > rstc);
      base  = post ? (n - rstc - 1) : n;
      in1   = !post && (a1 >= 0) && (n >= lo1) && (n <= hi1);
      in2   = !post && (a2 >= 0) && (n >= lo2) && (n <= hi2);
      busy1 = (a1 >= 0) && (n > a1) && ((d1 < 0) || (n <= d1));
      busy2 = (a2 >= 0) && (n > a2) && ((d2 < 0) || (n <= d2));
      pfx   = $sformatf("%s@%0d", name, n);
      check_eq({pfx, " digit"}, 32'(digit_cnt), 32'(base % DIGITS));
      check_eq({pfx, " minor"}, 32'(minor_cnt), 32'((base / DIGITS) % MINORS));
      check_eq({pfx, " mstart"}, 32'(minor_start), 32'((base % DIGITS) == 0));
      check_eq({pfx, " t_out"}, 32'(t_out), 32'((in1 && !w1) || (in2 && !w2)));
      check_eq({pfx, " t_in"}, 32'(t_in), 32'((in1 && w1) || (in2 && w2)));
      check_eq({pfx, " tank"}, 32'(tank_idx), in1 ? 32'(tk1) : (in2 ? 32'(tk2) : 32'd0));
      check_eq({pfx, " done"}, 32'(done), 32'(!post && ((n == d1) || (n == d2))));
      check_eq({pfx, " ready"}, 32'(ready), 32'(post || !(busy1 || busy2)));
      req = 1'b0; req_addr = '0; req_write = 1'b0; req_long = 1'b0; rst = 1'b0;
      if (n == a1) begin
        req = 1'b1; req_addr = addr1; req_write = w1; req_long = l1;
      end else if (n == a2) begin
        req = 1'b1; req_addr = addr2; req_write = w2; req_long = l2;
      end else if (n == spur) begin
        req = 1'b1; req_addr = saddr; req_write = 1'b1; req_long = 1'b1;
      end
      if (n == rstc) rst = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1; req = 1'b0; req_addr = '0; req_write = 1'b0; req_long = 1'b0;

    // Reset values and free-running counters only
    run_case("idle", 40,
             -1, 10'h000, 1'b0, 1'b0, 0, 0, 0, -1,
             -1, 10'h000, 1'b0, 1'b0, 0, 0, 0, -1,
             -1, 10'h000, -1);

    // Short read tank 5 minor 5, spurious request during WAIT, back-to-back write
    // accepted the cycle after done while minor 6 is in progress -> full revolution
    run_case("short", 705,
             0,   10'h0A5, 1'b0, 1'b0, 90,  107, 5, 108,
             109, 10'h066, 1'b1, 1'b0, 684, 701, 3, 702,
             50,  10'h3E0, -1);

    // Accept at digit 0 of the target minor -> full revolution wait
    run_case("fullrev", 597,
             0,  10'h000, 1'b0, 1'b0, 576, 593, 0, 594,
             -1, 10'h000, 1'b0, 1'b0, 0,   0,   0, -1,
             -1, 10'h000, -1);

    // Long write with odd address -> minors 30 and 31 of tank 31
    run_case("long", 580,
             0,  10'h3FF, 1'b1, 1'b1, 540, 575, 31, 576,
             -1, 10'h000, 1'b0, 1'b0, 0,   0,   0,  -1,
             -1, 10'h000, -1);

    // Minimum latency: accept on the last digit of the preceding minor cycle
    run_case("lat1", 40,
             17, 10'h041, 1'b0, 1'b0, 18, 35, 2, 36,
             -1, 10'h000, 1'b0, 1'b0, 0,  0,  0, -1,
             -1, 10'h000, -1);

    // Reset asserted at cycle 95 in the middle of the short read
    run_case("rstmid", 130,
             0,  10'h0A5, 1'b0, 1'b0, 90, 95, 5, -1,
             -1, 10'h000, 1'b0, 1'b0, 0,  0,  0, -1,
             -1, 10'h000, 95);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/edsac_tank_sequencer.md
# edsac_tank_sequencer

Sequences access to the mercury-delay-line store for the EDSAC control section. It generates the free-running digit and minor-cycle timing and accepts one store request at a time. It then waits for the addressed word to circulate to the tank output and drives the tank-select index and the in/out gates for exactly the word's minor cycle(s). It sits between the order/operand fetch logic and the per-tank distribution blocks, which consume its gate outputs.

## Interface
Parameters:
- `N_TANKS`, 32: number of long tanks; tank index width is `$clog2(N_TANKS)`.
- `MINORS_PER_TANK`, 32: minor cycles (short words) per tank revolution.
- `DIGITS_PER_MINOR`, 18: digit periods (clock cycles) per minor cycle.

Ports:
- `clk`, in, 1: single system clock; one digit period per cycle.
- `rst`, in, 1: reset, synchronous and active-high.
- `req`, in, 1: request valid.
- `req_addr`, in, 10: `[9:5]` tank, `[4:0]` minor cycle.
- `req_write`, in, 1: 1 = write (gate into tank), 0 = read (gate out of tank).
- `req_long`, in, 1: 1 = long word (two minor cycles; `req_addr[0]` ignored, treated as 0).
- `ready`, out, 1: high when a request can be accepted.
- `done`, out, 1: one-cycle pulse when the transfer completes.
- `tank_idx`, out, 5: selected tank, valid while a gate is high.
- `t_in`, out, 1: write gate.
- `t_out`, out, 1: read gate.
- `digit_cnt`, out, 5: current digit period, 0..DIGITS_PER_MINOR-1.
- `minor_cnt`, out, 5: current minor cycle, 0..MINORS_PER_TANK-1.
- `minor_start`, out, 1: high when `digit_cnt == 0`.

## Operation
- Timing counters:
  - `digit_cnt` increments every cycle and wraps at DIGITS_PER_MINOR-1 to 0.
  - `minor_cnt` increments when `digit_cnt` wraps and itself wraps at MINORS_PER_TANK-1 to 0.
  - The counters free-run in every state.
- Handshake: a request is accepted on a cycle with `req && ready`. The address, write and long flags are latched on that cycle. `req` is ignored while `ready` is low; no queueing.
- FSM states:
  - IDLE: `ready = 1`. Accept moves to WAIT.
  - WAIT: holds until the counters reach the target word.
  - XFER: the gate is open.
  - DONE: one cycle, `done = 1`, then returns to IDLE.
- Target start is the first cycle strictly after the accept cycle on which `digit_cnt == 0` and `minor_cnt == target_minor`. If a request is accepted during the target minor cycle itself, including at its digit 0, the sequencer waits a full revolution. Partial words are never gated.
- During XFER:
  - `t_out` (read) or `t_in` (write) is high, never both.
  - `tank_idx` equals the latched tank.
  - The gate stays high for exactly DIGITS_PER_MINOR cycles (short) or 2×DIGITS_PER_MINOR cycles (long: minor cycles `target` and `target+1`). Long targets are always even, so no wrap occurs within a word.
- The gates are registered outputs. They must be high exactly on the cycles where the counters show the target minor cycle(s), so the FSM enters XFER from WAIT one cycle early, on the cycle with `digit_cnt == DIGITS_PER_MINOR-1` and `minor_cnt == target_minor-1 (mod MINORS_PER_TANK)`.
- `tank_idx` is 0 outside XFER.

## Timing
- Reset values: `digit_cnt = 0`, `minor_cnt = 0`, FSM = IDLE, `ready = 1`, `done = 0`, `t_in = 0`, `t_out = 0`, `tank_idx = 0`, `minor_start = 1`. The first cycle after `rst` falls shows counters (0,0).
- Reset mid-operation: on the next edge all gates drop, `done` does not pulse, and the in-flight request is discarded.
- Latency from accept to gate start: 1 to MINORS_PER_TANK×DIGITS_PER_MINOR cycles (1..576 at defaults).
- `done` is asserted on the cycle immediately after the last gated cycle. `ready` returns high on the cycle after `done`.
- Back-to-back: a request accepted the cycle after `done` is legal. If its target is the minor cycle now in progress, it waits a full revolution.

## Test plan
- Reset: hold `rst` for 3 cycles, then release -> all outputs at reset values. `digit_cnt` 0,1..17,0 and `minor_cnt` increments on wrap. `minor_start` is high every 18th cycle.
- Short read: request at cycle 0 after reset with `req_addr = 10'h0A5` (tank 5, minor 5), `req_write = 0`, `req_long = 0` -> `t_out = 1` and `tank_idx = 5` on cycles 90..107. `done` pulses at cycle 108 and `ready` is high at cycle 109. `t_in` stays 0 throughout.
- Full-revolution wait: request `req_addr = 10'h000` accepted at cycle 0 (counters at (0,0)) -> `t_out` high on cycles 576..593 and `done` pulses at cycle 594.
- Long write with odd address: `req_addr = 10'h3FF`, `req_write = 1`, `req_long = 1`, accepted at cycle 0 -> treated as minor 30. `t_in = 1` and `tank_idx = 31` on cycles 540..575, and `done` pulses at cycle 576.
- Handshake: during WAIT, pulse `req` with a different address -> ignored, with no effect on gates or latched target. A request issued the cycle after `done` is accepted.
- Reset mid-XFER: assert `rst` at cycle 95 of the short-read case -> `t_out` is 0 from cycle 96 and no `done` pulse. Counters restart at (0,0) when `rst` falls.
